// File: rtl/alu_status_handler_pkg.sv
// Shared definitions for the ALU status / exception handler slice.
//   - FSM state encoding
//   - exception cause codes
//   - ALU_status and exc_mask bit positions
//   - fixed exception handler vector
package alu_status_handler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_ODD      = 4'd4;
  localparam logic [3:0] CAUSE_OVERFLOW = 4'd12;
  localparam logic [3:0] CAUSE_DIV_ZERO = 4'd15;

  // ALU_status bit positions
  localparam int unsigned STAT_ZERO     = 7;
  localparam int unsigned STAT_OVERFLOW = 6;
  localparam int unsigned STAT_CARRY    = 5;
  localparam int unsigned STAT_NEGATIVE = 4;
  localparam int unsigned STAT_ODD      = 3;
  localparam int unsigned STAT_DIV_ZERO = 2;

  // exc_mask bit positions
  localparam int unsigned MASK_DIV_ZERO = 2;
  localparam int unsigned MASK_OVERFLOW = 1;
  localparam int unsigned MASK_ODD      = 0;

  // Bits [1:0] of ALU_status are unused and never accumulated.
  localparam logic [7:0] STICKY_MASK = 8'hFC;

  localparam logic [31:0] HANDLER_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/alu_status_handler_cause_encoder.sv
// alu_cause_encoder: combinational trap detection and cause priority.
//   status_valid : flags are meaningful this cycle
//   div_zero     : ALU divide-by-zero flag
//   overflow     : ALU overflow flag
//   odd_result   : ALU odd-result flag
//   exc_mask     : per-trap enables ([2] div-zero, [1] overflow, [0] odd)
//   trap         : an enabled trap condition is present
//   cause_code   : highest-priority enabled cause, CAUSE_NONE when no trap
module alu_cause_encoder
  import alu_status_handler_pkg::*;
(
  input  logic       status_valid,
  input  logic       div_zero,
  input  logic       overflow,
  input  logic       odd_result,
  input  logic [2:0] exc_mask,
  output logic       trap,
  output logic [3:0] cause_code
);

  logic dz_en;
  logic ov_en;
  logic odd_en;

  always_comb begin
    dz_en  = status_valid & div_zero   & exc_mask[MASK_DIV_ZERO];
    ov_en  = status_valid & overflow   & exc_mask[MASK_OVERFLOW];
    odd_en = status_valid & odd_result & exc_mask[MASK_ODD];
    trap   = dz_en | ov_en | odd_en;

    cause_code = CAUSE_NONE;
    if (dz_en)       cause_code = CAUSE_DIV_ZERO;
    else if (ov_en)  cause_code = CAUSE_OVERFLOW;
    else if (odd_en) cause_code = CAUSE_ODD;
  end

endmodule

// File: rtl/alu_status_handler.sv
// alu_status_handler: turns enabled ALU status flags into a precise
// exception request and tracks sticky flags / exception statistics.
//   clk, rst      : clock, synchronous active-high reset
//   status_valid  : ALU_status / ALU_ctrl / PC_current valid this cycle
//   ALU_status    : ALU flags (zero, ovf, carry, neg, odd, div0, -, -)
//   ALU_ctrl      : ALU op of the flagged result
//   PC_current    : PC of the instruction producing the result
//   exc_mask      : trap enables ([2] div-zero, [1] overflow, [0] odd)
//   exc_ack       : controller accepts the pending exception
//   eret          : handler finished
//   flags_clear   : clear sticky flags
//   exc_req       : exception pending (state REQ)
//   stall         : high in REQ and HANDLER
//   handler_PC    : constant handler vector
//   EPC, cause    : PC and cause code of the excepting instruction
//   flags_sticky  : OR-accumulated ALU flags ([1:0] always 0)
//   last_ctrl     : ALU_ctrl of the excepting instruction
//   exc_count     : saturating count of taken exceptions
module alu_status_handler
  import alu_status_handler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        status_valid,
  input  logic [7:0]  ALU_status,
  input  logic [3:0]  ALU_ctrl,
  input  logic [31:0] PC_current,
  input  logic [2:0]  exc_mask,
  input  logic        exc_ack,
  input  logic        eret,
  input  logic        flags_clear,
  output logic        exc_req,
  output logic        stall,
  output logic [31:0] handler_PC,
  output logic [31:0] EPC,
  output logic [3:0]  cause,
  output logic [7:0]  flags_sticky,
  output logic [3:0]  last_ctrl,
  output logic [7:0]  exc_count
);

  state_t     state;
  logic       trap;
  logic [3:0] cause_code;
  logic [7:0] sticky_base;

  alu_cause_encoder u_cause_encoder (
    .status_valid (status_valid),
    .div_zero     (ALU_status[STAT_DIV_ZERO]),
    .overflow     (ALU_status[STAT_OVERFLOW]),
    .odd_result   (ALU_status[STAT_ODD]),
    .exc_mask     (exc_mask),
    .trap         (trap),
    .cause_code   (cause_code)
  );

  assign handler_PC = HANDLER_VECTOR;

  // Clear takes effect before accumulation, so a same-cycle valid
  // status lands in an already-cleared register.
  always_comb begin
    sticky_base = flags_clear ? '0 : flags_sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      exc_req      <= 1'b0;
      stall        <= 1'b0;
      EPC          <= '0;
      cause        <= CAUSE_NONE;
      flags_sticky <= '0;
      last_ctrl    <= '0;
      exc_count    <= '0;
    end else begin
      flags_sticky <= status_valid ? (sticky_base | (ALU_status & STICKY_MASK))
                                   : sticky_base;

      unique case (state)
        ST_IDLE: begin
          if (trap) begin
            state     <= ST_REQ;
            exc_req   <= 1'b1;
            stall     <= 1'b1;
            EPC       <= PC_current;
            last_ctrl <= ALU_ctrl;
            cause     <= cause_code;
            if (exc_count != '1) exc_count <= exc_count + 8'd1;
          end
        end
        ST_REQ: begin
          if (exc_ack) begin
            state   <= ST_HANDLER;
            exc_req <= 1'b0;
          end
        end
        ST_HANDLER: begin
          if (eret) begin
            state <= ST_IDLE;
            stall <= 1'b0;
            cause <= CAUSE_NONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          exc_req <= 1'b0;
          stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule
